binary_multiplier: RTL and testbench

Sequential unsigned multiplier: accepts two WIDTH-bit operands through a valid/ready handshake and returns their full 2*WIDTH-bit product after a fixed number of clock cycles using an iterative shift-add datapath. Sits as a small arithmetic leaf block wherever a low-area multiply is needed. The default WIDTH=4 yields an 8-bit product.

---
 rtl/binary_multiplier_pkg.sv | 18 +
 rtl/binary_multiplier_if.sv | 35 +++
 rtl/binary_multiplier_ctrl.sv | 62 ++++++
 rtl/binary_multiplier.sv | 74 +++++++
 tb/tb_binary_multiplier.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/binary_multiplier_pkg.sv
// Shared constants and types for the iterative shift-add multiplier.
package binary_multiplier_pkg;

  // Operand width used when no override is given; the product is twice this.
  localparam int unsigned DefaultWidth = 4;

  // Control states: IDLE accepts operands, BUSY iterates over multiplier bits.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // Bits needed for a counter that must be able to hold the value width.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/binary_multiplier_if.sv
// Operand/result handshake bundle between a requester and the multiplier.
interface binary_multiplier_if
  import binary_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               out_valid;
  logic [2*WIDTH-1:0] product;

  // Requester side: presents operands, observes readiness and results.
  modport master (
    output in_valid,
    output a,
    output b,
    input  in_ready,
    input  out_valid,
    input  product
  );

  // Multiplier side.
  modport slave (
    input  in_valid,
    input  a,
    input  b,
    output in_ready,
    output out_valid,
    output product
  );

endinterface

// File: rtl/binary_multiplier_ctrl.sv
// Control FSM: sequences exactly WIDTH shift-add steps per accepted operation
// and produces the registered one-cycle completion pulse.
module binary_multiplier_ctrl
  import binary_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  output logic accept,
  output logic step,
  output logic last,
  output logic out_valid
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  state_e          state_q;
  logic [CntW-1:0] count_q;
  logic            out_valid_q;

  // Readiness is decoded straight from state; everything else is registered.
  assign in_ready  = (state_q == StIdle);
  assign accept    = in_ready & in_valid;
  assign step      = (state_q == StBusy);
  assign last      = step & (count_q == LastCount);
  assign out_valid = out_valid_q;

  // State, bit counter and completion pulse; no early exit on zero operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q <= StBusy;
            count_q <= '0;
          end
        end
        StBusy: begin
          count_q <= count_q + 1'b1;
          if (count_q == LastCount) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/binary_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per cycle, full-width
// product held until the next completion.
module binary_multiplier
  import binary_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic                clk,
  input  logic                rst,
  binary_multiplier_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;

  logic          accept;
  logic          step;
  logic          last;
  logic          in_ready;
  logic          out_valid;

  logic [PW-1:0]    a_q;
  logic [WIDTH-1:0] b_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    product_q;
  logic [PW-1:0]    acc_next;

  binary_multiplier_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (in_ready),
    .accept    (accept),
    .step      (step),
    .last      (last),
    .out_valid (out_valid)
  );

  // Partial sum including the current multiplier bit; also the final product
  // on the last step, so completion needs no extra cycle.
  always_comb begin
    acc_next = acc_q;
    if (b_q[0]) begin
      acc_next = acc_q + a_q;
    end
  end

  // Shift-add datapath; operands are only sampled on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      a_q   <= {{WIDTH{1'b0}}, bus.a};
      b_q   <= bus.b;
      acc_q <= '0;
    end else if (step) begin
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      acc_q <= acc_next;
      if (last) begin
        product_q <= acc_next;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.product   = product_q;

endmodule

// File: tb/tb_binary_multiplier.sv
// Self-checking bench: directed operations with literal results plus a
// timing-level reference model compared on every cycle.
module tb_binary_multiplier;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  binary_multiplier_if #(.WIDTH(W)) bus ();

  binary_multiplier #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: edge count and queue of (due edge, product).
  int             edge_n      = 0;
  int             due_q[$];
  int             prod_q[$];
  logic           exp_ready   = 1'b1;
  logic           exp_valid   = 1'b0;
  logic [2*W-1:0] exp_product = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reset clears any pending operation and the held product.
  always @(posedge rst) begin
    due_q.delete();
    prod_q.delete();
    exp_product = '0;
    exp_ready   = 1'b1;
  end

  // Accept model: an operation accepted at edge N completes in the cycle after N+W.
  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      due_q.delete();
      prod_q.delete();
      exp_product = '0;
    end else if (bus.in_valid === 1'b1 && exp_ready) begin
      due_q.push_back(edge_n + W);
      prod_q.push_back(int'(bus.a) * int'(bus.b));
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    exp_valid = 1'b0;
    if (!rst && due_q.size() > 0 && due_q[0] == edge_n) begin
      exp_valid   = 1'b1;
      exp_product = (2*W)'(prod_q[0]);
      void'(due_q.pop_front());
      void'(prod_q.pop_front());
    end
    exp_ready = rst ? 1'b1 : (due_q.size() == 0);
    check("m_in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check("m_out_valid", 32'(bus.out_valid), 32'(exp_valid));
    check("m_product", 32'(bus.product), 32'(exp_product));
  end

  // Present operands (DUT must be ready), then scramble them while busy.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~av;
    bus.b        = ~bv;
  endtask

  // Wait (bounded) for the completion pulse; returns at that negedge.
  task automatic wait_result(input string name, input int exp);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.out_valid !== 1'b1 && lat < 20);
    check({name, "_latency"}, 32'(lat), 32'(W + 1));
    check({name, "_product"}, 32'(bus.product), 32'(exp));
    check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int pulses[$];
    int got[$];
    int exp_got[4];
    int npulse;
    exp_got = '{0, 40, 130, 30};

    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_product", 32'(bus.product), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    start_op(4'd1, 4'd0);
    wait_result("t1", 0);
    @(negedge clk);
    check("t1_pulse_drop", 32'(bus.out_valid), 32'd0);

    @(posedge clk);
    #1;
    start_op(4'b1001, 4'b0010);
    wait_result("t2", 18);
    @(negedge clk);
    check("t2_pulse_drop", 32'(bus.out_valid), 32'd0);

    @(posedge clk);
    #1;
    start_op(4'b1101, 4'b0100);
    wait_result("t3", 52);
    @(negedge clk);
    check("t3_pulse_drop", 32'(bus.out_valid), 32'd0);

    // Abort mid-operation after two busy edges.
    @(posedge clk);
    #1;
    start_op(4'd9, 4'd9);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_product", 32'(bus.product), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    npulse = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) npulse++;
    end
    check("abort_no_pulse", 32'(npulse), 32'd0);

    // Back-to-back: second accept lands in the out_valid cycle.
    @(posedge clk);
    #1;
    start_op(4'd15, 4'd15);
    wait_result("t4", 225);
    start_op(4'd0, 4'd15);
    wait_result("t5", 0);

    // Continuous in_valid with operands changing every cycle.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = W'(i);
      bus.b        = W'(i + 3);
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        pulses.push_back(i);
        got.push_back(int'(bus.product));
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("stream_pulses", 32'(pulses.size()), 32'd4);
    if (pulses.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check("stream_product", 32'(got[k]), 32'(exp_got[k]));
        if (k > 0) check("stream_spacing", 32'(pulses[k] - pulses[k-1]), 32'd5);
      end
    end
    repeat (10) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
